// File: rtl/pi_loop_sequencer_pkg.sv
// rtl/pi_loop_sequencer_pkg.sv - FSM encodings and DAC range helpers for the PI loop sequencer
package pi_loop_sequencer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;
    localparam logic [1:0] ST_SEND  = 2'd3;

    // Largest positive DAC code for a signed word of width w
    function automatic logic signed [63:0] dac_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Most negative DAC code for a signed word of width w
    function automatic logic signed [63:0] dac_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/pi_saturate.sv
// rtl/pi_saturate.sv - arithmetic right shift followed by a signed clip to [lo, hi]
module pi_saturate #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 0
) (
    input  logic signed [WIDTH-1:0] din,
    input  logic signed [WIDTH-1:0] lo,
    input  logic signed [WIDTH-1:0] hi,
    output logic signed [WIDTH-1:0] value,
    output logic                    clipped
);

    logic signed [WIDTH-1:0] shifted;

    // Shift first so the clip limits apply to the scaled value
    always_comb begin
        shifted = din >>> SHIFT;
        value   = shifted;
        clipped = 1'b0;
        if (shifted > hi) begin
            value   = hi;
            clipped = 1'b1;
        end else if (shifted < lo) begin
            value   = lo;
            clipped = 1'b1;
        end
    end

endmodule

// File: rtl/pi_loop_sequencer.sv
// rtl/pi_loop_sequencer.sv - sample-rate sequencer around the external pd_pipeline block
module pi_loop_sequencer
    import pi_loop_sequencer_pkg::*;
#(
    parameter int                 INPUT_WIDTH    = 18,
    parameter int                 OUTPUT_WIDTH   = 32,
    parameter int                 DAC_WIDTH      = 20,
    parameter int                 PIPE_LATENCY   = 4,
    parameter int                 SHIFT          = 0,
    parameter logic signed [63:0] INTEGRAL_LIMIT = 64'sd1073741823
) (
    input  logic                    clk,
    input  logic                    rst_L,
    input  logic                    enable,
    input  logic                    integral_clear,
    input  logic [INPUT_WIDTH-1:0]  setpoint,
    input  logic [INPUT_WIDTH-1:0]  kp,
    input  logic [INPUT_WIDTH-1:0]  ki,
    input  logic [INPUT_WIDTH-1:0]  sample,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic [INPUT_WIDTH-1:0]  pl_actual,
    output logic [INPUT_WIDTH-1:0]  pl_setpoint,
    output logic [INPUT_WIDTH-1:0]  pl_kp,
    output logic [INPUT_WIDTH-1:0]  pl_ki,
    output logic [OUTPUT_WIDTH-1:0] pl_integral_input,
    input  logic [OUTPUT_WIDTH-1:0] pl_integral_result,
    input  logic [OUTPUT_WIDTH-1:0] pl_pd_result,
    output logic [DAC_WIDTH-1:0]    dac_value,
    output logic                    dac_valid,
    input  logic                    dac_ready,
    output logic                    saturated,
    output logic                    busy
);

    localparam logic signed [63:0]             DAC_MAX_W = dac_max(DAC_WIDTH);
    localparam logic signed [63:0]             DAC_MIN_W = dac_min(DAC_WIDTH);
    localparam logic signed [OUTPUT_WIDTH-1:0] DAC_MAX   = DAC_MAX_W[OUTPUT_WIDTH-1:0];
    localparam logic signed [OUTPUT_WIDTH-1:0] DAC_MIN   = DAC_MIN_W[OUTPUT_WIDTH-1:0];
    localparam logic signed [OUTPUT_WIDTH-1:0] INT_MAX   = INTEGRAL_LIMIT[OUTPUT_WIDTH-1:0];
    localparam logic signed [OUTPUT_WIDTH-1:0] INT_MIN   = -INT_MAX;
    localparam logic [7:0]                     CNT_LAST  = 8'(PIPE_LATENCY - 1);

    logic [1:0]                     state;
    logic [7:0]                     cnt;
    logic signed [OUTPUT_WIDTH-1:0] integral_q;
    logic signed [OUTPUT_WIDTH-1:0] dac_sat;
    logic                           dac_clipped;
    logic signed [OUTPUT_WIDTH-1:0] int_next;
    logic                           int_clamp_unused;
    logic                           clip_high;
    logic                           clip_low;
    logic                           windup_hold;

    pi_saturate #(
        .WIDTH (OUTPUT_WIDTH),
        .SHIFT (SHIFT)
    ) u_dac_sat (
        .din     (pl_pd_result),
        .lo      (DAC_MIN),
        .hi      (DAC_MAX),
        .value   (dac_sat),
        .clipped (dac_clipped)
    );

    pi_saturate #(
        .WIDTH (OUTPUT_WIDTH),
        .SHIFT (0)
    ) u_int_clamp (
        .din     (pl_integral_result),
        .lo      (INT_MIN),
        .hi      (INT_MAX),
        .value   (int_next),
        .clipped (int_clamp_unused)
    );

    assign sample_ready      = (state == ST_IDLE) && enable;
    assign dac_valid         = (state == ST_SEND);
    assign busy              = (state != ST_IDLE);
    assign pl_integral_input = integral_q;

    // A clip to the max code can only be the high rail since DAC_MIN != DAC_MAX
    // Anti-windup: refuse integral moves that would push further into the active rail
    always_comb begin
        clip_high   = dac_clipped && (dac_sat == DAC_MAX);
        clip_low    = dac_clipped && !clip_high;
        windup_hold = (clip_high && (int_next > integral_q)) ||
                      (clip_low  && (int_next < integral_q));
    end

    // Sequencer FSM, pipeline input holding, DAC output and integral state
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pl_actual   <= '0;
            pl_setpoint <= '0;
            pl_kp       <= '0;
            pl_ki       <= '0;
            integral_q  <= '0;
            dac_value   <= '0;
            saturated   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sample_valid && enable) begin
                        pl_actual   <= sample;
                        pl_setpoint <= setpoint;
                        pl_kp       <= kp;
                        pl_ki       <= ki;
                        cnt         <= '0;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == CNT_LAST) begin
                        state <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    dac_value <= dac_sat[DAC_WIDTH-1:0];
                    saturated <= dac_clipped;
                    if (!windup_hold) begin
                        integral_q <= int_next;
                    end
                    state <= ST_SEND;
                end
                ST_SEND: begin
                    if (dac_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // Clear wins over any same-cycle writeback
            if (integral_clear) begin
                integral_q <= '0;
            end
        end
    end

endmodule
